// File: rtl/switch_sampler.sv
// -----------------------------------------------------------------------------
// switch_sampler
//
// Sampling front end of the switch debounce path. The raw push-button input is
// synchronised to clk, sampled once per tick into a SAMPLES-deep shift
// register, and judged by a two-state hysteretic FSM that drives the
// debounced level. The two newest samples also feed a downstream AND stage.
//
// Parameters:
//   TICK_DIV  clock cycles per sample strobe (>= 2)
//   SAMPLES   shift-register depth / agreeing samples to change level (2..16)
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous, active-high reset
//   sw_in          in   raw switch input (asynchronous, bouncing)
//   tick           out  one-cycle sample strobe (combinational from counter)
//   q_1            out  newest sample, sreg[0]
//   q_2            out  previous sample, sreg[1]
//   sw_level       out  debounced switch level (registered)
//   press_pulse    out  one-cycle pulse on debounced 0->1 (registered)
//   release_pulse  out  one-cycle pulse on debounced 1->0 (registered)
//
// Configuration macro:
//   SWITCH_SAMPLER_EDGE_PULSE_EN  when defined, the press/release pulse
//   registers are built; when undefined, both pulse outputs are tied to 0.
// -----------------------------------------------------------------------------
module switch_sampler #(
  parameter int TICK_DIV = 250000,
  parameter int SAMPLES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_in,
  output logic tick,
  output logic q_1,
  output logic q_2,
  output logic sw_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int                CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_t;

  logic               s0;
  logic               sw_sync;
  logic [CNT_W-1:0]   cnt;
  logic [SAMPLES-1:0] sreg;
  logic               sreg_ones;
  logic               sreg_zeros;
  state_t             state;
  state_t             state_next;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser. sw_in is used nowhere else.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the
  // two stages into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0      <= 1'b0;
      sw_sync <= 1'b0;
    end else begin
      s0      <= sw_in;
      sw_sync <= s0;
    end
  end

  // ---------------------------------------------------------------------------
  // Tick counter: 0 .. TICK_DIV-1, wrapping. tick is decoded from the count so
  // it is low during and immediately after reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Sample shift register: the newest sample enters at bit 0 on the edge that
  // closes a tick cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (tick) begin
      sreg <= {sreg[SAMPLES-2:0], sw_sync};
    end
  end

  assign q_1        = sreg[0];
  assign q_2        = sreg[1];
  assign sreg_ones  = &sreg;
  assign sreg_zeros = ~|sreg;

  // ---------------------------------------------------------------------------
  // Debounce FSM. Only a unanimous sample window moves the state; any mixed
  // pattern holds it, giving hysteresis against bounce. The FSM looks at the
  // current (pre-shift) sreg, so a sample arriving on the same edge is judged
  // one cycle later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RELEASED;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: the default assignment at the top of a combinational block keeps
  // every path assigned, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      RELEASED: if (sreg_ones)  state_next = PRESSED;
      PRESSED:  if (sreg_zeros) state_next = RELEASED;
      default:  state_next = RELEASED;
    endcase
  end

`ifdef SWITCH_SAMPLER_EDGE_PULSE_EN
  logic press_d;
  logic release_d;
`endif

  // Output decode. sw_level is the state register itself, so it is registered.
  always_comb begin
    sw_level  = (state == PRESSED);
`ifdef SWITCH_SAMPLER_EDGE_PULSE_EN
    press_d   = (state == RELEASED) && sreg_ones;
    release_d = (state == PRESSED)  && sreg_zeros;
`endif
  end

`ifdef SWITCH_SAMPLER_EDGE_PULSE_EN
  // Pulse registers load on the same edge as the state change, so each pulse
  // coincides with the first cycle of the new sw_level. They cannot both be
  // high because their decodes depend on opposite states.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= press_d;
      release_pulse <= release_d;
    end
  end
`else
  assign press_pulse   = 1'b0;
  assign release_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_switch_sampler.sv
// -----------------------------------------------------------------------------
// tb_switch_sampler
//
// Scoreboard bench for switch_sampler with TICK_DIV=4, SAMPLES=3. Stimulus
// tasks advance a reference model that works from edge counts and a history
// of sampled input values, and push the expected output set for each cycle
// into a queue. An independent monitor pops one entry per cycle on the
// falling clock edge and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_switch_sampler;

  localparam int T = 4;
  localparam int S = 3;

`ifdef SWITCH_SAMPLER_EDGE_PULSE_EN
  localparam bit PULSE_EN = 1'b1;
`else
  localparam bit PULSE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sw_in = 1'b0;
  logic tick, q_1, q_2, sw_level, press_pulse, release_pulse;

  switch_sampler #(.TICK_DIV(T), .SAMPLES(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .sw_in         (sw_in),
    .tick          (tick),
    .q_1           (q_1),
    .q_2           (q_2),
    .sw_level      (sw_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit tick;
    bit q1;
    bit q2;
    bit level;
    bit pp;
    bit rp;
    int tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int edge_n;          // clock edges since reset release
  bit sw_hist[$];      // sw_hist[k] = sw_in seen at edge k+1
  bit samp[$];         // last S samples taken, oldest first
  bit m_level;
  int tag_n = 0;

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: one expected record per cycle, compared on the falling edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("tick[%0d]", e.tag),          tick,          e.tick);
      check($sformatf("q_1[%0d]", e.tag),           q_1,           e.q1);
      check($sformatf("q_2[%0d]", e.tag),           q_2,           e.q2);
      check($sformatf("sw_level[%0d]", e.tag),      sw_level,      e.level);
      check($sformatf("press_pulse[%0d]", e.tag),   press_pulse,   e.pp);
      check($sformatf("release_pulse[%0d]", e.tag), release_pulse, e.rp);
    end
  end

  // One cycle with reset held: model returns to its reset picture.
  task automatic rst_cycle(input bit v);
    exp_t e;
    rst   = 1'b1;
    sw_in = v;
    edge_n = 0;
    sw_hist.delete();
    samp.delete();
    for (int i = 0; i < S; i++) samp.push_back(1'b0);
    m_level = 1'b0;
    e = '{tick: 1'b0, q1: 1'b0, q2: 1'b0, level: 1'b0, pp: 1'b0, rp: 1'b0, tag: tag_n++};
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  // One functional cycle: v is the sw_in value the next edge will see.
  task automatic step(input bit v);
    exp_t e;
    bit   all1, all0, pp, rp;
    rst   = 1'b0;
    sw_in = v;
    edge_n++;
    sw_hist.push_back(v);
    // Level decision uses the sample window as it stood before this edge.
    all1 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < S; i++) begin
      all1 &= samp[i];
      all0 &= ~samp[i];
    end
    pp = 1'b0;
    rp = 1'b0;
    if (!m_level && all1) begin
      m_level = 1'b1;
      pp = 1'b1;
    end else if (m_level && all0) begin
      m_level = 1'b0;
      rp = 1'b1;
    end
    // Edges that are multiples of T close a tick cycle; the sample taken is
    // the synchronised input, i.e. sw_in as seen two edges earlier.
    if (edge_n % T == 0) begin
      samp.push_back(edge_n >= 3 ? sw_hist[edge_n - 3] : 1'b0);
      void'(samp.pop_front());
    end
    e.tick  = (edge_n % T == T - 1);
    e.q1    = samp[S - 1];
    e.q2    = samp[S - 2];
    e.level = m_level;
    e.pp    = pp & PULSE_EN;
    e.rp    = rp & PULSE_EN;
    e.tag   = tag_n++;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    int lat;
    int n_press;
    int n_rel;
    bit in_range;
    bit v;
    int hold;

    // ---------------- Reset with sw_in high ----------------
    for (int i = 0; i < 10; i++) rst_cycle(1'b1);
    check("reset_tick",     tick,     1'b0);
    check("reset_q_1",      q_1,      1'b0);
    check("reset_sw_level", sw_level, 1'b0);
    // First tick and cadence are covered by the scoreboard over these cycles.
    for (int i = 0; i < 13; i++) step(1'b0);

    // ---------------- Clean press with latency bound ----------------
    for (int i = 0; i < 3; i++) rst_cycle(1'b0);
    hold = $urandom_range(0, 7);
    for (int i = 0; i < hold; i++) step(1'b0);
    lat = 0;
    n_press = 0;
    while (sw_level !== 1'b1 && lat < 40) begin
      step(1'b1);
      lat++;
      if (press_pulse === 1'b1) n_press++;
    end
    in_range = (lat >= 2 + (S - 1) * T + 2) && (lat <= 2 + S * T + 1);
    check("press_latency_in_range", in_range, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      if (press_pulse === 1'b1) n_press++;
    end
    check("clean_press_pulse_count", n_press == (PULSE_EN ? 1 : 0), 1'b1);

    // ---------------- Release with a 3-cycle glitch ----------------
    n_rel = 0;
    for (int i = 0; i < 6; i++) begin step(1'b0); if (release_pulse === 1'b1) n_rel++; end
    for (int i = 0; i < 3; i++) begin step(1'b1); if (release_pulse === 1'b1) n_rel++; end
    for (int i = 0; i < 30; i++) begin step(1'b0); if (release_pulse === 1'b1) n_rel++; end
    check("release_level_low",   sw_level, 1'b0);
    check("release_pulse_count", n_rel == (PULSE_EN ? 1 : 0), 1'b1);

    // ---------------- Bounce then stable press ----------------
    n_press = 0;
    for (int seg = 0; seg < 8; seg++)
      for (int i = 0; i < 5; i++) begin
        step(seg % 2 == 0);
        if (press_pulse === 1'b1) n_press++;
      end
    check("bounce_level_low",   sw_level, 1'b0);
    check("bounce_no_pulse",    n_press == 0, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step(1'b1);
      if (press_pulse === 1'b1) n_press++;
    end
    check("bounce_level_high",  sw_level, 1'b1);
    check("bounce_press_count", n_press == (PULSE_EN ? 1 : 0), 1'b1);

    // ---------------- Async reset mid-operation ----------------
    lat = 0;
    while (!(m_level && (edge_n % T == 2)) && lat < 40) begin
      step(1'b1);
      lat++;
    end
    check("async_rst_precondition", (m_level && (edge_n % T == 2)), 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_sw_level", sw_level,      1'b0);
    check("async_rst_q_1",      q_1,           1'b0);
    check("async_rst_q_2",      q_2,           1'b0);
    check("async_rst_tick",     tick,          1'b0);
    check("async_rst_release",  release_pulse, 1'b0);
    for (int i = 0; i < 3; i++) rst_cycle(1'b1);

    // ---------------- Randomised runs ----------------
    for (int run = 0; run < 150; run++) begin
      v    = $urandom_range(0, 1);
      hold = $urandom_range(1, 14);
      for (int i = 0; i < hold; i++) step(v);
    end

    // Drain the scoreboard.
    @(negedge clk);
    #1;
    check("scoreboard_drained", exp_q.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
